// File: rtl/configf_pkg.sv
// Shared constants, state encoding and frame builder for the ADC configuration
// SPI engine.
package configf_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int DATA_BITS   = 16;
  localparam int COMM_BITS   = FRAME_BITS - DATA_BITS;
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

  // Communication-byte field positions
  localparam int COMM_RW_BIT = 6;
  localparam int COMM_RS_MSB = 5;
  localparam int COMM_RS_LSB = 3;
  localparam int RS_BITS     = COMM_RS_MSB - COMM_RS_LSB + 1;

  // One-hot state encoding
  localparam int         STATE_BITS  = 5;
  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_CS_SETUP = 5'b00010;
  localparam logic [4:0] ST_SHIFT    = 5'b00100;
  localparam logic [4:0] ST_CS_HOLD  = 5'b01000;
  localparam logic [4:0] ST_DONE     = 5'b10000;

  typedef struct packed {
    logic                  is_read;
    logic [FRAME_BITS-1:0] frame;
  } cmd_t;

  // RW bit in the comm byte is 1 for reads; the data field is zero on reads.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 is_write,
    input logic [RS_BITS-1:0]   rs,
    input logic [DATA_BITS-1:0] wdata
  );
    logic [COMM_BITS-1:0] comm;
    logic [DATA_BITS-1:0] payload;
    comm                          = '0;
    comm[COMM_RW_BIT]             = ~is_write;
    comm[COMM_RS_MSB:COMM_RS_LSB] = rs;
    payload                       = is_write ? wdata : '0;
    return {comm, payload};
  endfunction

endpackage

// File: rtl/configf_sclk_div.sv
// SCLK half-period divider: times the low/high phases of each SPI bit and
// counts bits across the 24-bit frame while enabled.
module configf_sclk_div
  import configf_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 fall_tick,
  output logic                 rise_tick,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 last_bit
);

  localparam int HALF_W = $clog2(CLK_DIV);

  logic [HALF_W-1:0] half_cnt;
  logic              high_phase;
  logic              half_end;

  assign half_end  = (half_cnt == HALF_W'(CLK_DIV - 1));
  // rise_tick ends a low phase, fall_tick ends a high phase (incl. the last bit)
  assign rise_tick = en & half_end & ~high_phase;
  assign fall_tick = en & half_end &  high_phase;
  assign last_bit  = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt   <= '0;
      high_phase <= 1'b0;
      bit_cnt    <= '0;
    end else if (!en) begin
      half_cnt   <= '0;
      high_phase <= 1'b0;
      bit_cnt    <= '0;
    end else if (half_end) begin
      half_cnt   <= '0;
      high_phase <= ~high_phase;
      if (high_phase) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/configf_host.sv
// ADC configuration SPI command engine: accepts one register command per
// strobe, shifts a 24-bit mode-3 frame and returns the read word.
module configf_host
  import configf_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 user_cmd_en_in,
  input  logic [7:0]           user_addr_in,
  input  logic [DATA_BITS-1:0] user_wrrd_num_in,
  output logic                 user_cmd_done_out,
  output logic [DATA_BITS-1:0] user_rd_data_out,
  output logic                 user_rd_valid_out,
  output logic                 user_busy_out,
  output logic                 spi_cs_n,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int WAIT_W = $clog2(CLK_DIV);

  logic [STATE_BITS-1:0] state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  wait_end;
  cmd_t                  cmd_q;
  logic [DATA_BITS-1:0]  rx_q;
  logic [FRAME_BITS-1:0] frame_next;

  logic                  fall_tick;
  logic                  rise_tick;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  last_bit;

  // Address bits 6:3 carry no meaning for this device.
  logic unused_addr_bits;
  assign unused_addr_bits = ^user_addr_in[6:3];

  assign frame_next = build_frame(user_addr_in[7], user_addr_in[2:0], user_wrrd_num_in);
  assign wait_end   = (wait_cnt == WAIT_W'(CLK_DIV - 1));

  configf_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk       (clk),
    .reset     (reset),
    .en        (state == ST_SHIFT),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick),
    .bit_cnt   (bit_cnt),
    .last_bit  (last_bit)
  );

  // Outputs are updated on the same edge as the state change that implies
  // them, so every pin is a plain register with no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      wait_cnt          <= '0;
      cmd_q             <= '0;
      rx_q              <= '0;
      spi_cs_n          <= 1'b1;
      spi_sclk          <= 1'b1;
      spi_mosi          <= 1'b0;
      user_cmd_done_out <= 1'b0;
      user_rd_valid_out <= 1'b0;
      user_busy_out     <= 1'b0;
      user_rd_data_out  <= '0;
    end else begin
      user_cmd_done_out <= 1'b0;
      user_rd_valid_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (user_cmd_en_in) begin
            cmd_q.frame   <= frame_next;
            cmd_q.is_read <= ~user_addr_in[7];
            wait_cnt      <= '0;
            spi_cs_n      <= 1'b0;
            spi_mosi      <= frame_next[FRAME_BITS-1];
            user_busy_out <= 1'b1;
            state         <= ST_CS_SETUP;
          end
        end

        ST_CS_SETUP: begin
          if (wait_end) begin
            wait_cnt <= '0;
            spi_sclk <= 1'b0;
            state    <= ST_SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (rise_tick) begin
            spi_sclk <= 1'b1;
            rx_q     <= {rx_q[DATA_BITS-2:0], spi_miso};
          end else if (fall_tick) begin
            if (last_bit) begin
              state <= ST_CS_HOLD;
            end else begin
              // bit_cnt is the bit just finished; present the next one
              spi_sclk <= 1'b0;
              spi_mosi <= cmd_q.frame[BIT_CNT_W'(FRAME_BITS - 2) - bit_cnt];
            end
          end
        end

        ST_CS_HOLD: begin
          if (wait_end) begin
            wait_cnt          <= '0;
            spi_cs_n          <= 1'b1;
            spi_mosi          <= 1'b0;
            user_cmd_done_out <= 1'b1;
            if (cmd_q.is_read) begin
              user_rd_data_out  <= rx_q;
              user_rd_valid_out <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          user_busy_out <= 1'b0;
          state         <= ST_IDLE;
        end

        default: begin
          wait_cnt      <= '0;
          spi_cs_n      <= 1'b1;
          spi_sclk      <= 1'b1;
          spi_mosi      <= 1'b0;
          user_busy_out <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_configf_host.sv
// Bench for configf_host: two instances (CLK_DIV=2 and 5) checked cycle by
// cycle against a timing model derived from the frame-timing formulas.
module tb_configf_host;

  localparam int D_A = 2;
  localparam int D_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic        en_a, en_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic        miso_a, miso_b;
  logic        done_a, done_b, valid_a, valid_b, busy_a, busy_b;
  logic [15:0] rd_a, rd_b;
  logic        cs_a, cs_b, sclk_a, sclk_b, mosi_a, mosi_b;

  configf_host #(.CLK_DIV(D_A)) u_dut_a (
    .clk               (clk),
    .reset             (reset_a),
    .user_cmd_en_in    (en_a),
    .user_addr_in      (addr_a),
    .user_wrrd_num_in  (wd_a),
    .user_cmd_done_out (done_a),
    .user_rd_data_out  (rd_a),
    .user_rd_valid_out (valid_a),
    .user_busy_out     (busy_a),
    .spi_cs_n          (cs_a),
    .spi_sclk          (sclk_a),
    .spi_mosi          (mosi_a),
    .spi_miso          (miso_a)
  );

  configf_host #(.CLK_DIV(D_B)) u_dut_b (
    .clk               (clk),
    .reset             (reset_b),
    .user_cmd_en_in    (en_b),
    .user_addr_in      (addr_b),
    .user_wrrd_num_in  (wd_b),
    .user_cmd_done_out (done_b),
    .user_rd_data_out  (rd_b),
    .user_rd_valid_out (valid_b),
    .user_busy_out     (busy_b),
    .spi_cs_n          (cs_b),
    .spi_sclk          (sclk_b),
    .spi_mosi          (mosi_b),
    .spi_miso          (miso_b)
  );

  int          sel;
  int          n_vec;
  int          n_bad;
  logic [15:0] exp_rd [2];

  logic        o_done, o_valid, o_busy, o_cs, o_sclk, o_mosi;
  logic [15:0] o_rd;

  always_comb begin
    if (sel == 0) begin
      o_done = done_a; o_valid = valid_a; o_busy = busy_a;
      o_cs = cs_a; o_sclk = sclk_a; o_mosi = mosi_a; o_rd = rd_a;
    end else begin
      o_done = done_b; o_valid = valid_b; o_busy = busy_b;
      o_cs = cs_b; o_sclk = sclk_b; o_mosi = mosi_b; o_rd = rd_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (div %0d) at %0t: observed %0h expected %0h",
             tag, (sel == 0) ? D_A : D_B, $time, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [7:0] a, input logic [15:0] d, input logic m);
    if (sel == 0) begin
      en_a = en; addr_a = a; wd_a = d; miso_a = m;
    end else begin
      en_b = en; addr_b = a; wd_b = d; miso_b = m;
    end
  endtask

  task automatic set_reset(input logic r);
    if (sel == 0) reset_a = r;
    else          reset_b = r;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs_n"},  o_cs,    1);
    check({tag, "_sclk"},  o_sclk,  1);
    check({tag, "_mosi"},  o_mosi,  0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_rd"},    o_rd,    exp_rd[sel]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_idle("idle");
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
    end
  endtask

  // Strobe in cycle 0, then check every output in every cycle through done.
  // resp is what the ADC shifts back; only its low 16 bits should be kept.
  task automatic run_frame(input logic [7:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rword, input int stray_at,
                           input int reset_at, output logic [23:0] cap);
    int          d, last, t, k;
    logic        is_rd, m;
    logic [23:0] frame, resp;
    d     = (sel == 0) ? D_A : D_B;
    last  = 50 * d + 1;
    is_rd = ~addr[7];
    frame = {1'b0, is_rd, addr[2:0], 3'b000, (is_rd ? 16'h0000 : wdata)};
    resp  = {8'($urandom), rword};
    cap   = '0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_idle("pre");
      end else if (c == last) begin
        check("done_cs_n", o_cs,    1);
        check("done_sclk", o_sclk,  1);
        check("done_mosi", o_mosi,  0);
        check("done",      o_done,  1);
        check("valid",     o_valid, is_rd);
        check("done_busy", o_busy,  1);
        if (is_rd) exp_rd[sel] = rword;
        check("rd_data",   o_rd,    exp_rd[sel]);
      end else begin
        check("cs_n",     o_cs,    0);
        check("busy",     o_busy,  1);
        check("no_done",  o_done,  0);
        check("no_valid", o_valid, 0);
        check("rd_hold",  o_rd,    exp_rd[sel]);
        if (c <= d) begin
          check("setup_sclk", o_sclk, 1);
          check("setup_mosi", o_mosi, frame[23]);
        end else if (c <= 49 * d) begin
          t = c - d - 1;
          k = t / (2 * d);
          check("shift_sclk", o_sclk, (t % (2 * d)) >= d);
          check("shift_mosi", o_mosi, frame[23 - k]);
          if ((t % (2 * d)) == d) cap = {cap[22:0], o_mosi};
        end else begin
          check("hold_sclk", o_sclk, 1);
        end
      end
      if (c > d && c <= 49 * d) m = resp[23 - ((c - d - 1) / (2 * d))];
      else                      m = resp[23];
      if (c == stray_at) drive(1'b1, 8'h82, 16'($urandom), m);
      else               drive(c == 0, addr, wdata, m);
      if (c == reset_at) begin
        set_reset(1'b1);
        #1;
        exp_rd[sel] = 16'h0000;
        check_idle("rst_now");
        repeat (3) begin
          @(negedge clk);
          check_idle("rst_hold");
        end
        set_reset(1'b0);
        drive(1'b0, 8'h00, 16'h0000, 1'b1);
        return;
      end
    end
  endtask

  logic [23:0] cap;
  logic [7:0]  r_addr;
  logic [15:0] r_data, r_word;

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    reset_a = 1'b1;
    reset_b = 1'b1;
    sel = 1; drive(1'b0, 8'h00, 16'h0000, 1'b1);
    sel = 0; drive(1'b0, 8'h00, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    check_idle("reset");
    sel = 1;
    check_idle("reset");
    reset_a = 1'b0;
    reset_b = 1'b0;

    // CLK_DIV = 2
    sel = 0;
    idle(2);
    run_frame(8'h81, 16'h0130, 16'h0000, -1, -1, cap);
    check("write_frame", cap, 24'h080130);
    idle(3);
    run_frame(8'h03, 16'h0000, 16'h1234, -1, 30, cap);
    idle(3);
    run_frame(8'h03, 16'h0000, 16'hA55A, -1, -1, cap);
    check("read_comm", cap[23:16], 8'h58);
    check("read_word", o_rd, 16'hA55A);
    idle(2);
    run_frame(8'h85, 16'hBEEF, 16'h0000, 40, -1, cap);
    idle(60);
    // back-to-back: each frame strobes in the first cycle busy is low
    run_frame(8'h86, 16'h5A5A, 16'h0000, -1, -1, cap);
    run_frame(8'h07, 16'h0000, 16'h3C3C, -1, -1, cap);
    run_frame(8'h82, 16'hFFFF, 16'h0000, -1, -1, cap);
    for (int i = 0; i < 6; i++) begin
      r_addr = 8'($urandom);
      r_data = 16'($urandom);
      r_word = 16'($urandom);
      run_frame(r_addr, r_data, r_word, -1, -1, cap);
      idle(int'($urandom_range(0, 3)));
    end

    // CLK_DIV = 5
    sel = 1;
    idle(2);
    run_frame(8'h04, 16'h0000, 16'hC3A5, -1, -1, cap);
    run_frame(8'hFA, 16'h1357, 16'h0000, -1, -1, cap);
    idle(1);
    r_addr = 8'($urandom) & 8'h7F;
    r_word = 16'($urandom);
    run_frame(r_addr, 16'h0000, r_word, -1, -1, cap);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
